leiwand_rv32_wait_mem: RTL
==========================

# leiwand_rv32_wait_mem

Parametrised memory slave for the leiwand_rv32 SoC, successor to the single-cycle bench memory. It decodes its own address window, adds a programmable number of wait states, and supports byte-lane writes. It sits directly on the core's valid/ready memory bus, so several instances (ROM image, RAM, slow region) can share one bus without external decode logic.

## Interface
- WORDS, 4096: depth in 32-bit words; power of two, ≥ 4.
- BASE_ADDR, 32'h20400000: byte address of word 0; WORDS×4-aligned.
- WAIT_STATES, 0: extra cycles before ready; 0..15.
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- valid  in  1  request from core; held until ready.
- ready  out  1  one-cycle completion pulse.
- wen  in  4  byte-lane write enables; 4'b0000 means read.
- addr  in  32  byte address; bits [1:0] ignored.
- wdata  in  `MEM_WIDTH  write data, lane n = bits [8n+7:8n].
- rdata  out  `MEM_WIDTH  read data, valid while ready is high.
- hit  out  1  combinational: addr inside window.
- err  out  1  error flag (present only with LEIWAND_RV32_MEM_ERR_EN).

## Operation
- hit = (addr ≥ BASE_ADDR) && (addr < BASE_ADDR + 4×WORDS), computed 33 bits wide so a window ending at 2^32 does not wrap.
- Word index = (addr − BASE_ADDR) >> 2, truncated to log2(WORDS) bits.
- FSM: IDLE → (valid && hit) → WAIT if WAIT_STATES > 0, else RESP; WAIT counts down a 4-bit counter loaded with WAIT_STATES−1 → RESP at zero; RESP → IDLE unconditionally.
- The access is performed on entry to RESP:
  - Read: rdata is registered from the array.
  - Write: only the lanes enabled in wen are written.
- addr, wen and wdata are sampled at the IDLE→ acceptance edge and held internally. Later changes by the requester are ignored.
- valid dropped while in WAIT: return to IDLE, no write, no ready.
- valid still high in IDLE after a RESP: treated as a new request. The requester must drop valid or present the next request.
- Write response: ready pulses; rdata keeps its previous value.
- Memory contents are not cleared by reset. rdata resets to 0.

## Timing
- Reset values: ready=0, rdata=0, err=0, FSM=IDLE, counter=0.
- Latency: ready is high in cycle N+1+WAIT_STATES, where N is the cycle valid&&hit is first sampled.
- ready is high for exactly one cycle per accepted request.
- Minimum issue interval is 2+WAIT_STATES cycles (RESP→IDLE costs one cycle).
- Reset asserted mid-access: immediate abort, no write commits, ready=0.
- A write completing on the same edge that reset asserts does not commit.

## Configuration
- LEIWAND_RV32_MEM_ERR_EN defined:
  - A request with valid && !hit && wen≠0 is also accepted and follows the same FSM and latency.
  - At RESP: ready=1 and err=1 (err is high only with ready); no write; rdata=0.
  - Reads outside the window are still ignored, so another slave can answer them.
- Not defined: the err port is absent, and any !hit request is ignored (ready stays 0).

## Structure
- leiwand_rv32_constants.v: `MEM_WIDTH and the FSM state encodings MEM_ST_IDLE/WAIT/RESP.
- Sub-module leiwand_rv32_mem_array:
  - WORDS×32 storage with a synchronous 4-lane byte write and a registered read.
  - Exposes a hierarchical mem[] so benches can preload binaries with the existing byte-swap load flow.
- FSM, counter and address decode live in the top module.

## Test plan
- WAIT_STATES=0: read 0x20400000 preloaded with 0x00000013 → ready and rdata=0x00000013 exactly one cycle after valid.
- WAIT_STATES=3: write 0xDEADBEEF with wen=4'b0101 to 0x20400004 over old value 0x11223344, then read → ready 4 cycles after valid; readback 0x11AD33EF.
- Window edge: addr=BASE+4×WORDS−4 → hit=1, served; addr=BASE+4×WORDS → hit=0, no ready for 20 cycles.
- Reset (low) pulsed two cycles into a WAIT_STATES=5 write → ready never rises, target word unchanged, rdata=0.
- Back-to-back: valid held high over 3 reads at WAIT_STATES=1 → ready pulses every 3 cycles, with correct data each time.
- With LEIWAND_RV32_MEM_ERR_EN: write to 0x10000000 → ready and err high together after 1+WAIT_STATES cycles, array unchanged. A read to the same address gets no response.

Source files
------------

// File: rtl/leiwand_rv32_wait_mem_pkg.sv
// rtl/leiwand_rv32_wait_mem_pkg.sv - shared constants, FSM states and lane-merge helper
// Purpose: data width, access FSM encoding and the byte-lane merge used by the
//          wait-state memory slave and its storage array.
package leiwand_rv32_wait_mem_pkg;

  localparam int MEM_WIDTH = 32;

  typedef enum logic [1:0] {
    MEM_ST_IDLE = 2'd0,
    MEM_ST_WAIT = 2'd1,
    MEM_ST_RESP = 2'd2
  } mem_state_e;

  // Replace only the byte lanes selected by wen; other lanes keep old_word.
  function automatic logic [MEM_WIDTH-1:0] lane_merge(
    input logic [MEM_WIDTH-1:0] old_word,
    input logic [MEM_WIDTH-1:0] new_word,
    input logic [3:0]           wen
  );
    logic [MEM_WIDTH-1:0] res;
    res = old_word;
    for (int b = 0; b < 4; b++) begin
      if (wen[b]) res[8*b +: 8] = new_word[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/leiwand_rv32_mem_array.sv
// rtl/leiwand_rv32_mem_array.sv - WORDS x 32 storage with byte-lane write and registered read
// Purpose: backing store for leiwand_rv32_wait_mem. The array is named mem so
//          benches can preload images hierarchically (u_array.mem[i]).
// Ports:
//   clk    in   clock
//   reset  in   asynchronous active-low reset (clears rdata only, never mem)
//   we     in   write strobe, lanes selected by wen
//   re     in   read strobe, loads rdata from mem[idx]
//   clr    in   forces rdata to zero (error response)
//   idx    in   word index
//   wen    in   byte-lane enables
//   wdata  in   write data
//   rdata  out  registered read data
module leiwand_rv32_mem_array
  import leiwand_rv32_wait_mem_pkg::*;
#(
  parameter int unsigned WORDS = 4096,
  parameter int          AW    = 12
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 we,
  input  logic                 re,
  input  logic                 clr,
  input  logic [AW-1:0]        idx,
  input  logic [3:0]           wen,
  input  logic [MEM_WIDTH-1:0] wdata,
  output logic [MEM_WIDTH-1:0] rdata
);

  logic [MEM_WIDTH-1:0] mem [WORDS];

  // Contents survive reset on purpose: preloaded images must outlive a reset.
  always_ff @(posedge clk) begin
    if (we) mem[idx] <= lane_merge(mem[idx], wdata, wen);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdata <= '0;
    end else if (clr) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[idx];
    end
  end

endmodule

// File: rtl/leiwand_rv32_wait_mem.sv
// rtl/leiwand_rv32_wait_mem.sv - self-decoding memory slave with programmable wait states
// Purpose: valid/ready memory slave with its own address window, WAIT_STATES
//          extra cycles per access and byte-lane writes.
// Optional: LEIWAND_RV32_MEM_ERR_EN adds the err port and answers writes
//           outside the window with an error response.
// Ports:
//   clk    in   clock
//   reset  in   asynchronous active-low reset
//   valid  in   request, held until ready
//   ready  out  one-cycle completion pulse
//   wen    in   byte-lane write enables, 0 = read
//   addr   in   byte address, bits [1:0] ignored
//   wdata  in   write data
//   rdata  out  read data, valid while ready is high
//   hit    out  addr inside the window (combinational)
//   err    out  error response flag (LEIWAND_RV32_MEM_ERR_EN only)
module leiwand_rv32_wait_mem
  import leiwand_rv32_wait_mem_pkg::*;
#(
  parameter int unsigned WORDS       = 4096,
  parameter logic [31:0] BASE_ADDR   = 32'h20400000,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 valid,
  output logic                 ready,
  input  logic [3:0]           wen,
  input  logic [31:0]          addr,
  input  logic [MEM_WIDTH-1:0] wdata,
  output logic [MEM_WIDTH-1:0] rdata,
  output logic                 hit
`ifdef LEIWAND_RV32_MEM_ERR_EN
  ,
  output logic                 err
`endif
);

  localparam int          AW        = $clog2(WORDS);
  // 33 bits so a window ending exactly at 2^32 does not wrap to zero.
  localparam logic [32:0] LIMIT     = {1'b0, BASE_ADDR} + 33'(WORDS) * 33'd4;
  localparam logic [3:0]  WAIT_LOAD = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  mem_state_e           state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [AW-1:0]        idx_in, idx_q, a_idx;
  logic [3:0]           wen_q, a_wen;
  logic [MEM_WIDTH-1:0] wdata_q, a_wdata;
  logic                 miss_in, miss_q, a_miss;
  logic                 accept, enter_resp, use_live;
  logic                 arr_we, arr_re, arr_clr;

  assign hit    = ({1'b0, addr} >= {1'b0, BASE_ADDR}) && ({1'b0, addr} < LIMIT);
  assign idx_in = AW'((addr - BASE_ADDR) >> 2);

`ifdef LEIWAND_RV32_MEM_ERR_EN
  // Out-of-window reads stay unanswered so another slave may claim them.
  assign miss_in = !hit && (wen != 4'b0000);
`else
  assign miss_in = 1'b0;
`endif

  assign accept = valid && (hit || miss_in);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= MEM_ST_IDLE;
      cnt_q   <= 4'd0;
      idx_q   <= '0;
      wen_q   <= 4'd0;
      wdata_q <= '0;
      miss_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == MEM_ST_IDLE && accept) begin
        idx_q   <= idx_in;
        wen_q   <= wen;
        wdata_q <= wdata;
        miss_q  <= miss_in;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    enter_resp = 1'b0;
    unique case (state_q)
      MEM_ST_IDLE: begin
        if (accept) begin
          if (WAIT_STATES == 0) begin
            state_d    = MEM_ST_RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = MEM_ST_WAIT;
            cnt_d   = WAIT_LOAD;
          end
        end
      end
      MEM_ST_WAIT: begin
        if (!valid) begin
          state_d = MEM_ST_IDLE;
          cnt_d   = 4'd0;
        end else if (cnt_q == 4'd0) begin
          state_d    = MEM_ST_RESP;
          enter_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      MEM_ST_RESP: state_d = MEM_ST_IDLE;
      default:     state_d = MEM_ST_IDLE;
    endcase
  end

  // With zero wait states the access happens on the acceptance edge itself,
  // before the held copies are loaded, so the live bus is used then.
  assign use_live = (state_q == MEM_ST_IDLE);
  assign a_idx    = use_live ? idx_in  : idx_q;
  assign a_wen    = use_live ? wen     : wen_q;
  assign a_wdata  = use_live ? wdata   : wdata_q;
  assign a_miss   = use_live ? miss_in : miss_q;

  // Gating with reset keeps a write that coincides with reset from committing.
  assign arr_we  = enter_resp && !a_miss && (a_wen != 4'b0000) && reset;
  assign arr_re  = enter_resp && !a_miss && (a_wen == 4'b0000);
  assign arr_clr = enter_resp && a_miss;

  assign ready = (state_q == MEM_ST_RESP);

`ifdef LEIWAND_RV32_MEM_ERR_EN
  assign err = ready && miss_q;
`endif

  leiwand_rv32_mem_array #(
    .WORDS (WORDS),
    .AW    (AW)
  ) u_array (
    .clk   (clk),
    .reset (reset),
    .we    (arr_we),
    .re    (arr_re),
    .clr   (arr_clr),
    .idx   (a_idx),
    .wen   (a_wen),
    .wdata (a_wdata),
    .rdata (rdata)
  );

endmodule
